// File: rtl/slot_free_list.sv
// slot_free_list: free-slot bitmap allocator for OoO slot pools.
// Allocation grants the lowest-index free slot; release sets the returned
// slot's bit back. Keeps a registered free count, supports flush, and
// raises a sticky error on double frees.
// Optional feature macro: SLOT_FREE_LIST_BYPASS_EN -- when defined, an
// empty list may hand a slot being legally freed in the same cycle
// straight to the requester.
module slot_free_list #(
    parameter int NUM_SLOTS = 16,
    parameter int IDX_WIDTH = $clog2(NUM_SLOTS),
    parameter int CNT_WIDTH = IDX_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [IDX_WIDTH-1:0] alloc_idx,
    input  logic                 free_valid,
    input  logic [IDX_WIDTH-1:0] free_idx,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] free_count,
    output logic                 empty,
    output logic                 full,
    output logic                 dbl_free_err
);

    localparam logic [CNT_WIDTH-1:0] ALL_FREE = CNT_WIDTH'(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] free_map;
    logic [NUM_SLOTS-1:0] map_next;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 err_next;
    logic [IDX_WIDTH-1:0] first_idx;
    logic                 slot_is_free;
    logic                 legal_free;
    logic                 dbl_free;
    logic                 bypass_hit;

    assign empty = (free_count == '0);
    assign full  = (free_count == ALL_FREE);

    // Flush wins over any release, so a freed index is ignored while flushing.
    assign slot_is_free = free_map[free_idx];
    assign legal_free   = free_valid & ~slot_is_free & ~flush;
    assign dbl_free     = free_valid &  slot_is_free & ~flush;

`ifdef SLOT_FREE_LIST_BYPASS_EN
    // Only an empty list forwards; otherwise the bitmap already has a slot.
    assign bypass_hit = rst_n & alloc_req & empty & legal_free;
`else
    assign bypass_hit = 1'b0;
`endif

    // Lowest-index free slot; scanning downward lets the lowest match win.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                first_idx = IDX_WIDTH'(i);
            end
        end
    end

    // Grant decision: never during reset or flush, never from an empty list
    // unless the same-cycle bypass is taking the returned slot.
    always_comb begin
        alloc_gnt = rst_n & ~flush & alloc_req & (~empty | bypass_hit);
        alloc_idx = bypass_hit ? free_idx : first_idx;
    end

    // Next-state for bitmap, counter and sticky error.
    always_comb begin
        map_next = free_map;
        cnt_next = free_count;
        err_next = dbl_free_err;
        if (flush) begin
            map_next = '1;
            cnt_next = ALL_FREE;
            err_next = 1'b0;
        end else begin
            if (dbl_free) begin
                err_next = 1'b1;
            end
            // A bypassed slot goes straight back out, so bitmap and count stay put.
            if (!bypass_hit) begin
                if (legal_free) begin
                    map_next[free_idx] = 1'b1;
                end
                // Clear after set: a double free aimed at alloc_idx must not
                // keep the just-granted slot marked free.
                if (alloc_gnt) begin
                    map_next[alloc_idx] = 1'b0;
                end
                cnt_next = free_count - CNT_WIDTH'(alloc_gnt) + CNT_WIDTH'(legal_free);
            end
        end
    end

    // State registers; asynchronous reset returns every slot to the pool.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map     <= '1;
            free_count   <= ALL_FREE;
            dbl_free_err <= 1'b0;
        end else begin
            free_map     <= map_next;
            free_count   <= cnt_next;
            dbl_free_err <= err_next;
        end
    end

endmodule

// File: tb/tb_slot_free_list.sv
// tb_slot_free_list: scoreboard bench for slot_free_list. Stimulus computes
// expected per-cycle outputs from a set-of-free-slots model and queues them;
// a monitor on the falling edge pops and compares.
module tb_slot_free_list;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam int CW = 5;

    logic          clk;
    logic          rst_n;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [IW-1:0] alloc_idx;
    logic          free_valid;
    logic [IW-1:0] free_idx;
    logic          flush;
    logic [CW-1:0] free_count;
    logic          empty;
    logic          full;
    logic          dbl_free_err;

    slot_free_list #(.NUM_SLOTS(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_idx    (alloc_idx),
        .free_valid   (free_valid),
        .free_idx     (free_idx),
        .flush        (flush),
        .free_count   (free_count),
        .empty        (empty),
        .full         (full),
        .dbl_free_err (dbl_free_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit gnt;
        int idx;
        int cnt;
        bit emp;
        bit ful;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: which slots are free, plus the sticky error.
    bit   free_m[N];
    bit   err_m;

    function automatic int count_free();
        int c = 0;
        for (int i = 0; i < N; i++) c += free_m[i] ? 1 : 0;
        return c;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (free_m[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) free_m[i] = 1'b1;
        err_m = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock of stimulus: drive, predict, queue expectation, advance model.
    task automatic step(input bit rst, input bit req, input bit fv, input int fi, input bit fl);
        exp_t e;
        int   cnt;
        bit   legal;
        bit   dbl;
        bit   byp;
        rst_n      = rst;
        alloc_req  = req;
        free_valid = fv;
        free_idx   = IW'(fi);
        flush      = fl;
        if (!rst) model_reset();
        cnt   = count_free();
        legal = rst && fv && !free_m[fi] && !fl;
        dbl   = rst && fv &&  free_m[fi] && !fl;
        byp   = 1'b0;
        e.gnt = rst && req && (cnt != 0) && !fl;
        e.idx = lowest_free();
`ifdef SLOT_FREE_LIST_BYPASS_EN
        if (rst && req && cnt == 0 && legal) begin
            byp   = 1'b1;
            e.gnt = 1'b1;
            e.idx = fi;
        end
`endif
        e.cnt = cnt;
        e.emp = (cnt == 0);
        e.ful = (cnt == N);
        e.err = err_m;
        exp_q.push_back(e);
        if (rst) begin
            if (fl) begin
                model_reset();
            end else begin
                if (dbl) err_m = 1'b1;
                if (!byp) begin
                    if (legal) free_m[fi] = 1'b1;
                    if (e.gnt) free_m[e.idx] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT's outputs once per cycle against the queue.
    always @(negedge clk) begin
        exp_t m;
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            check("alloc_gnt", int'(alloc_gnt), int'(m.gnt));
            if (m.gnt && alloc_gnt) check("alloc_idx", int'(alloc_idx), m.idx);
            check("free_count", int'(free_count), m.cnt);
            check("empty", int'(empty), int'(m.emp));
            check("full", int'(full), int'(m.ful));
            check("dbl_free_err", int'(dbl_free_err), int'(m.err));
        end
    end

    initial begin
        int alloc_list[$];
        int r;
        int fi;
        rst_n      = 1'b0;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_idx   = '0;
        flush      = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with a request pending: no grants, all free.
        repeat (3) step(0, 1, 0, 0, 0);
        // Three grants 0,1,2, then the remaining 13, then an empty request.
        repeat (16) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        // Return 9 then 3, re-allocate: 3 first, then 9.
        step(1, 0, 1, 9, 0);
        step(1, 0, 1, 3, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Flush, allocate 0..3, then alloc (4) together with freeing 2.
        step(1, 0, 0, 0, 1);
        repeat (4) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 2, 0);
        step(1, 1, 0, 0, 0);
        // Double free of 7 (still free), then flush with a request.
        step(1, 0, 1, 7, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        // Drain the pool, then request while freeing 5 in the same cycle.
        repeat (16) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 5, 0);
        step(1, 0, 0, 0, 0);
        // Async reset mid-operation.
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 3, 0);
        step(1, 0, 0, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            alloc_list.delete();
            for (int i = 0; i < N; i++) if (!free_m[i]) alloc_list.push_back(i);
            r = $urandom_range(0, 199);
            if (alloc_list.size() > 0 && $urandom_range(0, 99) < 85)
                fi = alloc_list[$urandom_range(0, alloc_list.size() - 1)];
            else
                fi = $urandom_range(0, N - 1);
            step(r != 199, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, fi, r < 4);
        end
        step(1, 0, 0, 0, 0);

        // Let the monitor consume the last expectation.
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_free_list.md
Name: slot_free_list

Overview:
- Free-slot bitmap allocator for the OoO core (ROB / issue-queue / phys-reg slot pools).
- Owns a NUM_SLOTS-bit "slot free" bitmap.
- Allocation side: grants the lowest-index free slot, which is the first-one search over the bitmap.
- Release side: the inverse operation. It decodes a returned slot index back into a set bit.
- Maintains a free counter, supports pipeline flush, and flags double-frees.

Parameters:
- NUM_SLOTS, 16: number of slots (power of two, ≥2).
- IDX_WIDTH, $clog2(NUM_SLOTS): slot index width.
- CNT_WIDTH, IDX_WIDTH+1: free-count width (holds NUM_SLOTS).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alloc_req  input  1  consumer requests one slot this cycle.
- alloc_gnt  output  1  allocation granted this cycle.
- alloc_idx  output  IDX_WIDTH  granted slot index; valid when alloc_gnt=1.
- free_valid  input  1  a slot is being returned this cycle.
- free_idx  input  IDX_WIDTH  index of returned slot.
- flush  input  1  mark every slot free (misprediction recovery).
- free_count  output  CNT_WIDTH  number of free slots (registered).
- empty  output  1  free_count==0 (no slot available).
- full  output  1  free_count==NUM_SLOTS (all slots free).
- dbl_free_err  output  1  sticky: a free of an already-free slot occurred.

Behaviour:
- State:
  - free_map[NUM_SLOTS-1:0]: bit=1 means the slot is free.
  - free_count register.
  - dbl_free_err register.
- Reset (rst_n=0, async):
  - free_map = all ones, free_count = NUM_SLOTS, dbl_free_err = 0.
  - alloc_gnt forced 0 while rst_n=0.
- Allocation path (combinational from registered free_map):
  - alloc_idx = lowest set bit of free_map; alloc_idx = 0 when free_map = 0.
  - alloc_gnt = alloc_req & ~empty & ~flush.
  - On alloc_gnt, bit alloc_idx is cleared at the next rising edge. Latency: the granted slot is unavailable from the next cycle.
- Release path (registered):
  - When free_valid=1 and free_map[free_idx]=0, bit free_idx is set at the next edge.
  - When free_valid=1 and free_map[free_idx]=1 (double free): free_map is unchanged, free_count is unchanged, dbl_free_err is set to 1 and stays 1 until reset or flush.
  - free_idx ≥ NUM_SLOTS cannot occur for power-of-two NUM_SLOTS; no check is required.
- Simultaneous alloc + free in one cycle:
  - Both updates apply; free_count is unchanged.
  - A freed slot is not visible to the allocator in the same cycle, so no bypass (see Optional Feature).
  - alloc_idx can never equal a legal free_idx, because one slot is free and the other is allocated. If the free is a double free on alloc_idx, the double-free rule applies and the allocation still clears the bit.
- Counter update:
  - free_count_next = free_count − alloc_gnt + (legal free).
  - Arithmetic is CNT_WIDTH unsigned and never wraps, by construction.
- Flush:
  - Highest priority. At the next edge free_map = all ones, free_count = NUM_SLOTS, dbl_free_err = 0.
  - During a flush cycle, alloc_gnt = 0 and free_valid is ignored.
- empty and full are decoded from the registered free_count, so they carry no combinational path from the inputs.
- Boundaries:
  - Last slot allocated: empty=1 next cycle.
  - alloc_req while empty: alloc_gnt=0, no state change.
  - Asynchronous reset asserted mid-operation discards all state immediately.

Optional Feature:
- Macro: SLOT_FREE_LIST_BYPASS_EN.
- Defined:
  - When empty=1, alloc_req=1, free_valid=1 and the free is legal, alloc_gnt=1 and alloc_idx=free_idx in the same cycle.
  - free_map bit stays 0 and free_count stays 0.
  - Flush still suppresses the grant.
- Undefined: no bypass; an empty list never grants.

Test Plan:
- Reset release, alloc_req held for 3 cycles → alloc_idx 0, 1, 2 with alloc_gnt=1 each cycle; free_count 16→13.
- Allocate all 16 slots → 16th grant has alloc_idx=15; next cycle empty=1, and a further alloc_req gives alloc_gnt=0.
- From full allocation, free_idx=9 then 3 on consecutive cycles → next alloc_idx=3, then 9; free_count returns to 0.
- Same cycle: alloc_req=1 (idx 4) plus free_idx=2 (allocated) → free_count unchanged; next alloc_idx=2.
- free_idx=7 while slot 7 is already free → dbl_free_err=1 next cycle, free_count unchanged; flush → dbl_free_err=0, full=1, alloc_gnt=0 during the flush cycle.
- Bypass build: empty, alloc_req=1, free_idx=5 in the same cycle → alloc_gnt=1, alloc_idx=5, free_count stays 0. Same stimulus in a non-bypass build → alloc_gnt=0, free_count=1.
